screen_text_writer: RTL

- Write-side companion of the VGA character screen RAM: turns a byte stream from the processor (putchar-style valid/ready) into single-cycle writes on the RAM's write port.
- Maintains the text cursor and interprets control codes CR, LF, BS and FF.
- Clears rows on wrap so the raster reader never shows stale text.
- Sits between the processor's I/O store path and the screen RAM write port; cursor position is exported for cursor rendering.

---
 rtl/screen_pkg.sv | 29 ++
 rtl/screen_text_writer_if.sv | 22 ++
 rtl/screen_sweep.sv | 66 ++++++
 rtl/screen_text_writer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared constants, state encoding and address packing for the screen text writer
package screen_pkg;

  localparam int DEFAULT_COLS = 80;
  localparam int DEFAULT_ROWS = 40;
  localparam int ADDR_W       = 15;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUT,
    ST_CLEAR_ROW,
    ST_CLEAR_ALL
  } state_t;

  // Same packing the raster reader uses for its read address.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [6:0] row, input logic [7:0] col);
    return {row, col};
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/screen_text_writer_if.sv
// rtl/screen_text_writer_if.sv - byte stream in, screen RAM write port out
interface screen_text_writer_if;
  import screen_pkg::*;

  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output char_valid, char_data,
    input  char_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  char_valid, char_data,
    output char_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/screen_sweep.sv
// rtl/screen_sweep.sv - row/column sweep counter for single-row and full-screen clears
module screen_sweep
  import screen_pkg::*;
#(
  parameter int COLS = DEFAULT_COLS,
  parameter int ROWS = DEFAULT_ROWS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              row_only,
  input  logic [6:0]        start_row,
  output logic [ADDR_W-1:0] addr,
  output logic              active,
  output logic              done
);

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);

  logic [7:0] col_q;
  logic [6:0] row_q;
  logic       row_only_q;
  logic       last_col;
  logic       last_row;

  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);
  assign done     = active && last_col && (row_only_q || last_row);

  // addr is the cell to be written in the following cycle, so the caller can register it.
  always_comb begin
    addr = pack_addr(row_q, col_q);
    if (start)
      addr = pack_addr(row_only ? start_row : 7'd0, 8'd0);
    else if (last_col)
      addr = pack_addr(row_q + 7'd1, 8'd0);
    else
      addr = pack_addr(row_q, col_q + 8'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= 1'b0;
      row_only_q <= 1'b0;
      row_q      <= 7'd0;
      col_q      <= 8'd0;
    end else if (start) begin
      active     <= 1'b1;
      row_only_q <= row_only;
      row_q      <= row_only ? start_row : 7'd0;
      col_q      <= 8'd0;
    end else if (active) begin
      if (last_col) begin
        col_q <= 8'd0;
        if (row_only_q || last_row)
          active <= 1'b0;
        else
          row_q <= row_q + 7'd1;
      end else begin
        col_q <= col_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/screen_text_writer.sv
// rtl/screen_text_writer.sv - putchar byte stream to screen RAM writes with cursor and control codes
module screen_text_writer
  import screen_pkg::*;
#(
  parameter int COLS           = DEFAULT_COLS,
  parameter int ROWS           = DEFAULT_ROWS,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  screen_text_writer_if.slave  bus,
  output logic [7:0]           cur_x,
  output logic [6:0]           cur_y,
  output logic                 busy
);

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);

  state_t            state_q, state_d;
  logic [7:0]        cur_x_q, x_d;
  logic [6:0]        cur_y_q, y_d;
  logic              put_adv_q, put_adv_d;
  logic              char_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;

  logic              accept;
  logic              put_load;
  logic [7:0]        put_byte;
  logic [6:0]        wrap_y;
  logic              sw_start, sw_row_only, sw_active, sw_done;
  logic [6:0]        sw_row;
  logic [ADDR_W-1:0] sw_addr;

  assign accept = bus.char_valid && char_ready_q;
  assign wrap_y = (cur_y_q == LAST_ROW) ? 7'd0 : cur_y_q + 7'd1;

  screen_sweep #(.COLS(COLS), .ROWS(ROWS)) u_sweep (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (sw_start),
    .row_only  (sw_row_only),
    .start_row (sw_row),
    .addr      (sw_addr),
    .active    (sw_active),
    .done      (sw_done)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = cur_x_q;
    y_d         = cur_y_q;
    put_adv_d   = put_adv_q;
    put_load    = 1'b0;
    put_byte    = 8'h00;
    sw_start    = 1'b0;
    sw_row_only = 1'b1;
    sw_row      = wrap_y;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(bus.char_data)) begin
            state_d   = ST_PUT;
            put_load  = 1'b1;
            put_byte  = bus.char_data;
            put_adv_d = 1'b1;
          end else if (bus.char_data == ASCII_LF) begin
            x_d      = 8'd0;
            y_d      = wrap_y;
            state_d  = ST_CLEAR_ROW;
            sw_start = 1'b1;
          end else if (bus.char_data == ASCII_CR) begin
            x_d = 8'd0;
          end else if (bus.char_data == ASCII_BS) begin
            // Backspace erases the cell it steps back onto, without advancing afterwards.
            if (cur_x_q != 8'd0) begin
              x_d       = cur_x_q - 8'd1;
              state_d   = ST_PUT;
              put_load  = 1'b1;
              put_adv_d = 1'b0;
            end
          end else if (bus.char_data == ASCII_FF) begin
            state_d     = ST_CLEAR_ALL;
            sw_start    = 1'b1;
            sw_row_only = 1'b0;
          end
        end
      end
      ST_PUT: begin
        state_d = ST_IDLE;
        if (put_adv_q) begin
          if (cur_x_q == LAST_COL) begin
            x_d      = 8'd0;
            y_d      = wrap_y;
            state_d  = ST_CLEAR_ROW;
            sw_start = 1'b1;
          end else begin
            x_d = cur_x_q + 8'd1;
          end
        end
      end
      ST_CLEAR_ROW: begin
        if (sw_done)
          state_d = ST_IDLE;
      end
      ST_CLEAR_ALL: begin
        // Entered straight from reset with no sweep running when CLEAR_ON_RESET is set.
        if (!sw_active) begin
          sw_start    = 1'b1;
          sw_row_only = 1'b0;
        end else if (sw_done) begin
          state_d = ST_IDLE;
          x_d     = 8'd0;
          y_d     = 7'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR_ON_RESET ? ST_CLEAR_ALL : ST_IDLE;
      cur_x_q      <= 8'd0;
      cur_y_q      <= 7'd0;
      put_adv_q    <= 1'b0;
      char_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_x_q      <= x_d;
      cur_y_q      <= y_d;
      put_adv_q    <= put_adv_d;
      char_ready_q <= (state_d == ST_IDLE);
    end
  end

  // Write port is loaded one cycle ahead so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else if (put_load) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= pack_addr(y_d, x_d);
      wr_data_q <= put_byte;
    end else if (sw_start || (sw_active && !sw_done)) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= sw_addr;
      wr_data_q <= 8'h00;
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  assign bus.char_ready = char_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign cur_x          = cur_x_q;
  assign cur_y          = cur_y_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
